// File: rtl/bits_divider_if.sv
// Switch/LED bundle for the sequential divider: operands and start in, result and status out.
interface bits_divider_if #(
  parameter int width = 3
);
  logic [2*width-1:0] SW;
  logic               start;
  logic [width-1:0]   LEDR;
  logic [width-1:0]   LEDR_rem;
  logic               LEDR_busy;
  logic               LEDR_done;
  logic               LEDR_dz;

  modport master (
    output SW, start,
    input  LEDR, LEDR_rem, LEDR_busy, LEDR_done, LEDR_dz
  );

  modport slave (
    input  SW, start,
    output LEDR, LEDR_rem, LEDR_busy, LEDR_done, LEDR_dz
  );
endinterface

// File: rtl/bits_divider.sv
// Restoring unsigned divider, one quotient bit per clock, launched by a rising edge on start.
//   state | meaning
//   IDLE  | waiting for the first start edge after reset
//   CALC  | iterating, busy high, previous result still shown
//   DONE  | result and flags held until the next start edge
module bits_divider #(
  parameter int width = 3
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  bits_divider_if.slave bus
);
  localparam int CW = (width > 1) ? $clog2(width) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic             start_q, start_d;
  logic [width-1:0] dvd_q, dvd_d;
  logic [width-1:0] dvs_q, dvs_d;
  logic [width-1:0] rem_q, rem_d;
  logic [width-1:0] quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [width-1:0] ledr_q, ledr_d;
  logic [width-1:0] ledr_rem_q, ledr_rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic             start_edge;
  logic [width-1:0] sw_dvd;
  logic [width-1:0] sw_dvs;
  logic [width:0]   r1;
  logic [width:0]   diff;
  logic             no_borrow;

  assign sw_dvd     = bus.SW[width-1:0];
  assign sw_dvs     = bus.SW[2*width-1:width];
  assign start_edge = bus.start & ~start_q;

  // Trial subtraction uses the same ripple rule as the add/sub path: ~divisor with carry-in 1.
  assign r1        = {rem_q, dvd_q[width-1]};
  assign diff      = r1 + {1'b1, ~dvs_q} + (width+1)'(1);
  assign no_borrow = ~diff[width];

  always_comb begin
    state_d    = state_q;
    start_d    = bus.start;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    ledr_d     = ledr_q;
    ledr_rem_d = ledr_rem_q;
    busy_d     = busy_q;
    done_d     = done_q;
    dz_d       = dz_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_edge) begin
          dvd_d  = sw_dvd;
          dvs_d  = sw_dvs;
          done_d = 1'b0;
          dz_d   = 1'b0;
          if (sw_dvs == '0) begin
            state_d    = DONE;
            ledr_d     = '1;
            ledr_rem_d = sw_dvd;
            dz_d       = 1'b1;
            done_d     = 1'b1;
          end else begin
            state_d = CALC;
            busy_d  = 1'b1;
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = CW'(width - 1);
          end
        end
      end
      CALC: begin
        dvd_d = dvd_q << 1;
        rem_d = no_borrow ? diff[width-1:0] : r1[width-1:0];
        quo_d = width'({quo_q, no_borrow});
        if (cnt_q == '0) begin
          state_d    = DONE;
          ledr_d     = quo_d;
          ledr_rem_d = rem_d;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // start_q resets high so a start held through reset is not seen as an edge.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      start_q    <= 1'b1;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      ledr_q     <= '0;
      ledr_rem_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      ledr_q     <= ledr_d;
      ledr_rem_q <= ledr_rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dz_q       <= dz_d;
    end
  end

  assign bus.LEDR      = ledr_q;
  assign bus.LEDR_rem  = ledr_rem_q;
  assign bus.LEDR_busy = busy_q;
  assign bus.LEDR_done = done_q;
  assign bus.LEDR_dz   = dz_q;
endmodule

// File: tb/tb_bits_divider.sv
// Scoreboard bench for bits_divider: the driver queues expected results, the monitor checks them on time.
module tb_bits_divider;
  localparam int W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bits_divider_if #(.width(W)) dif();
  bits_divider #(.width(W)) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (dif)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           launch;
    int           due;
  } exp_t;

  exp_t sb[$];
  exp_t head;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: results are compared exactly at their due cycle; before that the op must be busy, not done.
  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() == 0) begin
        if (dif.LEDR_busy) chk("unexpected_busy", 32'(dif.LEDR_busy), 0);
      end else begin
        head = sb[0];
        if (cyc == head.due) begin
          chk("quotient",  32'(dif.LEDR),      32'(head.q));
          chk("remainder", 32'(dif.LEDR_rem),  32'(head.r));
          chk("dz",        32'(dif.LEDR_dz),   32'(head.dz));
          chk("done",      32'(dif.LEDR_done), 1);
          chk("busy_end",  32'(dif.LEDR_busy), 0);
          void'(sb.pop_front());
        end else if (cyc >= head.launch) begin
          chk("busy_calc", 32'(dif.LEDR_busy), 1);
          chk("done_calc", 32'(dif.LEDR_done), 0);
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    exp_t e;
    @(negedge clk);
    dif.SW    = {b, a};
    dif.start = 1'b1;
    e.q      = eq;
    e.r      = er;
    e.dz     = edz;
    e.launch = cyc + 1;
    e.due    = cyc + 1 + (edz ? 0 : W);
    sb.push_back(e);
  endtask

  task automatic drop_start();
    @(negedge clk);
    dif.start = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 0);
    sb.delete();
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    issue(a, b, eq, er, edz);
    drop_start();
    wait_empty();
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  vec_t vecs[5] = '{
    '{3'd7, 3'd2, 3'd3, 3'd1, 1'b0},
    '{3'd6, 3'd7, 3'd0, 3'd6, 1'b0},
    '{3'd7, 3'd1, 3'd7, 3'd0, 1'b0},
    '{3'd5, 3'd0, 3'd7, 3'd5, 1'b1},
    '{3'd4, 3'd2, 3'd2, 3'd0, 1'b0}
  };

  initial begin
    logic [W-1:0] ma, mb;
    dif.SW    = '0;
    dif.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ledr", 32'(dif.LEDR),      0);
    chk("rst_rem",  32'(dif.LEDR_rem),  0);
    chk("rst_busy", 32'(dif.LEDR_busy), 0);
    chk("rst_done", 32'(dif.LEDR_done), 0);
    chk("rst_dz",   32'(dif.LEDR_dz),   0);
    rst = 1'b0;

    foreach (vecs[i]) run(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);

    // Second edge and operand change during CALC must not disturb 7/2.
    issue(3'd7, 3'd2, 3'd3, 3'd1, 1'b0);
    @(negedge clk);
    dif.start = 1'b0;
    dif.SW    = {3'd3, 3'd3};
    @(negedge clk);
    dif.start = 1'b1;
    drop_start();
    wait_empty();

    // Start held for 10 clocks launches exactly one division.
    issue(3'd6, 3'd2, 3'd3, 3'd0, 1'b0);
    repeat (9) @(negedge clk);
    dif.start = 1'b0;
    wait_empty();
    repeat (3) @(negedge clk);
    chk("held_done", 32'(dif.LEDR_done), 1);
    chk("held_q",    32'(dif.LEDR),      3);

    // Reset mid-CALC with start held high, then no division until a fresh edge.
    issue(3'd7, 3'd3, 3'd2, 3'd1, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("arst_ledr", 32'(dif.LEDR),      0);
    chk("arst_rem",  32'(dif.LEDR_rem),  0);
    chk("arst_busy", 32'(dif.LEDR_busy), 0);
    chk("arst_done", 32'(dif.LEDR_done), 0);
    chk("arst_dz",   32'(dif.LEDR_dz),   0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_busy", 32'(dif.LEDR_busy), 0);
    chk("post_rst_done", 32'(dif.LEDR_done), 0);
    dif.start = 1'b0;
    run(3'd3, 3'd3, 3'd1, 3'd0, 1'b0);

    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        ma = W'(a);
        mb = W'(b);
        if (b == 0) run(ma, mb, 3'd7, ma, 1'b1);
        else        run(ma, mb, W'(a / b), W'(a % b), 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
